// File: rtl/ram_arbiter_2port.sv
// Two-port arbiter in front of a shared single-port RAM with a one-cycle registered read.
// Grants are combinational. Read data is routed back to the requester one cycle after its grant.
module ram_arbiter_2port #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 16,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              a_req,
  input  logic              a_write,
  input  logic [ADDR_W-1:0] a_address,
  input  logic [DATA_W-1:0] a_writedata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_readdata,
  input  logic              b_req,
  input  logic              b_write,
  input  logic [ADDR_W-1:0] b_address,
  input  logic [DATA_W-1:0] b_writedata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_readdata,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_write,
  output logic              ram_read,
  output logic [DATA_W-1:0] ram_writedata,
  input  logic [DATA_W-1:0] ram_readdata
);

  logic              ptr_r;        // 0 favours A, 1 favours B
  logic              rsp_valid_r;
  logic              rsp_id_r;     // 0 = A, 1 = B
  logic [ADDR_W-1:0] held_addr_r;
  logic [DATA_W-1:0] held_wdata_r;
  logic [DATA_W-1:0] a_rdata_r;
  logic [DATA_W-1:0] b_rdata_r;

  // Grant resolution: a lone request always wins, and a tie goes to the favoured port.
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (!reset_n) begin
      a_gnt = 1'b0;
      b_gnt = 1'b0;
    end else if (a_req && b_req) begin
      if ((FIXED_PRIO != 0) || !ptr_r) begin
        a_gnt = 1'b1;
      end else begin
        b_gnt = 1'b1;
      end
    end else begin
      a_gnt = a_req;
      b_gnt = b_req;
    end
  end

  // RAM command mux. Address and write data hold their last granted values while idle.
  always_comb begin
    ram_address   = held_addr_r;
    ram_writedata = held_wdata_r;
    ram_write     = 1'b0;
    ram_read      = 1'b0;
    if (a_gnt) begin
      ram_address   = a_address;
      ram_writedata = a_writedata;
      ram_write     = a_write;
      ram_read      = ~a_write;
    end else if (b_gnt) begin
      ram_address   = b_address;
      ram_writedata = b_writedata;
      ram_write     = b_write;
      ram_read      = ~b_write;
    end else begin
      ram_write     = 1'b0;
      ram_read      = 1'b0;
    end
  end

  // Response steering: valid is masked while reset is asserted, so an in-flight read is dropped.
  always_comb begin
    a_rvalid   = reset_n & rsp_valid_r & ~rsp_id_r;
    b_rvalid   = reset_n & rsp_valid_r & rsp_id_r;
    a_readdata = a_rvalid ? ram_readdata : a_rdata_r;
    b_readdata = b_rvalid ? ram_readdata : b_rdata_r;
  end

  // State: priority pointer, held RAM command, response tag and delivered read data.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptr_r        <= 1'b0;
      rsp_valid_r  <= 1'b0;
      rsp_id_r     <= 1'b0;
      held_addr_r  <= {ADDR_W{1'b0}};
      held_wdata_r <= {DATA_W{1'b0}};
      a_rdata_r    <= {DATA_W{1'b0}};
      b_rdata_r    <= {DATA_W{1'b0}};
    end else begin
      if (a_gnt || b_gnt) begin
        ptr_r        <= a_gnt;
        held_addr_r  <= ram_address;
        held_wdata_r <= ram_writedata;
      end
      rsp_valid_r <= ram_read;
      rsp_id_r    <= b_gnt;
      if (a_rvalid) begin
        a_rdata_r <= ram_readdata;
      end
      if (b_rvalid) begin
        b_rdata_r <= ram_readdata;
      end
    end
  end

endmodule

// File: doc/ram_arbiter_2port.md
RAM_ARBITER_2PORT -- requirements
Module: ram_arbiter_2port

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 12, RAM address width in bits.
REQ-002 The block SHALL have parameter DATA_W, default 16, RAM data width in bits.
REQ-003 The block SHALL have parameter FIXED_PRIO, default 0; 0 selects round-robin arbitration and 1 gives port A fixed priority.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 The block SHALL have, for each X in {a,b}, port X_req, input, 1 bit: access request.
REQ-007 The block SHALL have, for each X in {a,b}, port X_write, input, 1 bit: 1 means a write and 0 means a read.
REQ-008 The block SHALL have, for each X in {a,b}, port X_address, input, ADDR_W bits: word address.
REQ-009 The block SHALL have, for each X in {a,b}, port X_writedata, input, DATA_W bits: write data.
REQ-010 The block SHALL have, for each X in {a,b}, port X_gnt, output, 1 bit: request accepted this cycle.
REQ-011 The block SHALL have, for each X in {a,b}, port X_rvalid, output, 1 bit: X_readdata is valid this cycle.
REQ-012 The block SHALL have, for each X in {a,b}, port X_readdata, output, DATA_W bits: read data.
REQ-013 The block SHALL have port ram_address, output, ADDR_W bits: to the shared single-cycle-read RAM.
REQ-014 The block SHALL have port ram_write, output, 1 bit: RAM write strobe.
REQ-015 The block SHALL have port ram_read, output, 1 bit: RAM read strobe.
REQ-016 The block SHALL have port ram_writedata, output, DATA_W bits: RAM write data.
REQ-017 The block SHALL have port ram_readdata, input, DATA_W bits: RAM registered read data, valid one cycle after the address.

Function
REQ-018 X_gnt SHALL be combinational from X_req, the other port's request and the priority pointer; at most one grant SHALL be high per cycle.
REQ-019 A requester SHALL hold X_req, X_write, X_address and X_writedata stable until it sees X_gnt high; the access is consumed on the rising edge where X_gnt=1.
REQ-020 In a granted cycle, ram_address, ram_writedata and ram_write SHALL equal the granted port's signals, and ram_read SHALL equal NOT X_write.
REQ-021 With no grant, ram_write and ram_read SHALL be 0; ram_address and ram_writedata SHALL hold the last granted values (no toggling).
REQ-022 Round-robin mode: a 1-bit pointer ptr (0 favours A, 1 favours B) SHALL resolve simultaneous requests in favour of the favoured port.
REQ-023 Round-robin mode: after each grant, ptr SHALL update to favour the port not granted.
REQ-024 Round-robin mode: a lone request SHALL be granted regardless of ptr.
REQ-025 FIXED_PRIO=1: A SHALL always win a conflict and ptr SHALL be ignored.
REQ-026 Response pipeline: on each granted read, the registers rsp_valid=1 and rsp_id=port SHALL be captured; otherwise rsp_valid SHALL be captured as 0.
REQ-027 In cycle N+1 after a read granted in cycle N, X_rvalid SHALL be 1 only for port rsp_id, and X_readdata SHALL equal ram_readdata.
REQ-028 X_readdata SHALL hold its last delivered value when X_rvalid=0.
REQ-029 Writes SHALL produce no rvalid.
REQ-030 Throughput SHALL be one access per cycle, with back-to-back grants to the same or alternating ports and no bubble cycles.
REQ-031 A read of an address written in the immediately preceding cycle SHALL return the new data, since the RAM has committed it.
REQ-032 A read and a write to the same address in the same cycle SHALL be impossible, because there is only one grant per cycle.
REQ-033 Address wrap: addresses SHALL pass unmodified, with no range check; all 2^ADDR_W words are reachable.

Reset
REQ-034 While reset_n=0 at a rising edge: ptr SHALL be set to 0, rsp_valid to 0, the X_readdata registers to 0, and the held ram_address/ram_writedata to 0.
REQ-035 While reset_n=0: a_gnt, b_gnt, ram_write, ram_read, a_rvalid and b_rvalid SHALL be forced to 0, even if requests are high.
REQ-036 A read granted in the cycle before reset asserts SHALL NOT produce rvalid once reset is sampled; its response is discarded.
REQ-037 The first grant after reset release SHALL go to A if both ports request.

Verification
REQ-038 Reset for 2 cycles with a_req=b_req=1 -> no gnt/strobes during reset; first cycle after release -> a_gnt=1.
REQ-039 Preload mem[0x010]=0x1234; a_req read 0x010 in cycle N -> a_gnt=1 in N; a_rvalid=1, a_readdata=0x1234 in N+1; b_rvalid=0.
REQ-040 Both ports read continuously (A at 0x001, B at 0x002, holding 0xAAAA/0xBBBB) -> grants alternate A,B,A,B, and rvalid alternates one cycle later with correct data.
REQ-041 B writes 0xBEEF to 0x0FF in N, A reads 0x0FF in N+1 -> a_readdata=0xBEEF in N+2, and no rvalid in N+1.
REQ-042 FIXED_PRIO=1 with a_req held high for 5 cycles and b_req high -> b_gnt=0 for all 5 cycles; B is granted in the first cycle after a_req drops.
REQ-043 A read of 0xFFF granted with reset_n driven low the next cycle -> a_rvalid=0; after release the pipeline is idle and ptr=0.
